// File: rtl/in_conditioner.sv
// in_conditioner: conditions an asynchronous switch/sensor input for the fp block.
// Two-flop synchroniser, 4-state debounce FSM, registered rise/fall strobes, and
// saturating 16-bit counters of accepted rising edges and rejected glitches.

module in_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        raw_in,
  input  logic        clr,
  output logic        clean_out,
  output logic        rise_pulse,
  output logic        fall_pulse,
  output logic [15:0] event_cnt,
  output logic [15:0] glitch_cnt
);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_WAIT = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_WAIT = 2'd3
  } state_t;

  // The WAIT states accept when the count already reached DEBOUNCE_CYCLES-1,
  // i.e. when cnt+1 would equal DEBOUNCE_CYCLES. Comparing against the
  // precomputed constant avoids a width-extended adder in the compare path.
  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [15:0]      CntMax  = 16'hFFFF;

  logic             sync1_q;
  logic             sync2_q;
  logic             sync;
  state_t           state_q;
  logic [CNT_W-1:0] debCnt_q;
  logic             clean_q;
  logic             risePulse_q;
  logic             fallPulse_q;
  logic [15:0]      eventCnt_q;
  logic [15:0]      eventCnt_d;
  logic [15:0]      glitchCnt_q;
  logic [15:0]      glitchCnt_d;
  logic             riseAccept;
  logic             glitchSeen;

  assign sync = sync2_q;

  // Two-flop synchroniser; everything downstream sees only the second stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM with registered level and one-cycle strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LOW;
      debCnt_q    <= '0;
      clean_q     <= 1'b0;
      risePulse_q <= 1'b0;
      fallPulse_q <= 1'b0;
    end else begin
      risePulse_q <= 1'b0;
      fallPulse_q <= 1'b0;
      case (state_q)
        S_LOW: begin
          if (sync) begin
            state_q  <= S_RISE_WAIT;
            debCnt_q <= CntOne;
          end
        end
        S_RISE_WAIT: begin
          if (!sync) begin
            state_q  <= S_LOW;
            debCnt_q <= '0;
          end else if (debCnt_q == DebLast) begin
            state_q     <= S_HIGH;
            debCnt_q    <= '0;
            clean_q     <= 1'b1;
            risePulse_q <= 1'b1;
          end else begin
            debCnt_q <= debCnt_q + CntOne;
          end
        end
        S_HIGH: begin
          if (!sync) begin
            state_q  <= S_FALL_WAIT;
            debCnt_q <= CntOne;
          end
        end
        S_FALL_WAIT: begin
          if (sync) begin
            state_q  <= S_HIGH;
            debCnt_q <= '0;
          end else if (debCnt_q == DebLast) begin
            state_q     <= S_LOW;
            debCnt_q    <= '0;
            clean_q     <= 1'b0;
            fallPulse_q <= 1'b1;
          end else begin
            debCnt_q <= debCnt_q + CntOne;
          end
        end
        default: begin
          state_q  <= S_LOW;
          debCnt_q <= '0;
          clean_q  <= 1'b0;
        end
      endcase
    end
  end

  // Decode counter events from the same conditions the FSM acts on.
  always_comb begin
    riseAccept = (state_q == S_RISE_WAIT) && sync && (debCnt_q == DebLast);
    glitchSeen = ((state_q == S_RISE_WAIT) && !sync) ||
                 ((state_q == S_FALL_WAIT) && sync);
  end

  // Next counter values: clear beats increment, increments stop at all-ones.
  always_comb begin
    eventCnt_d  = eventCnt_q;
    glitchCnt_d = glitchCnt_q;
    if (clr) begin
      eventCnt_d  = '0;
      glitchCnt_d = '0;
    end else begin
      if (riseAccept && (eventCnt_q != CntMax)) begin
        eventCnt_d = eventCnt_q + 16'd1;
      end
      if (glitchSeen && (glitchCnt_q != CntMax)) begin
        glitchCnt_d = glitchCnt_q + 16'd1;
      end
    end
  end

  // Status counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eventCnt_q  <= '0;
      glitchCnt_q <= '0;
    end else begin
      eventCnt_q  <= eventCnt_d;
      glitchCnt_q <= glitchCnt_d;
    end
  end

  assign clean_out  = clean_q;
  assign rise_pulse = risePulse_q;
  assign fall_pulse = fallPulse_q;
  assign event_cnt  = eventCnt_q;
  assign glitch_cnt = glitchCnt_q;

  // The two strobes are mutually exclusive by construction.
  strobesExclusive: assert property (@(posedge clk) disable iff (!rst)
    !(rise_pulse && fall_pulse));

endmodule

// File: tb/tb_in_conditioner.sv
// tb_in_conditioner: directed checks of the input conditioner with
// DEBOUNCE_CYCLES=4 (acceptance 5 edges after the first raw sample).

module tb_in_conditioner;

  logic        clk;
  logic        rst;
  logic        raw_in;
  logic        clr;
  logic        clean_out;
  logic        rise_pulse;
  logic        fall_pulse;
  logic [15:0] event_cnt;
  logic [15:0] glitch_cnt;

  int checkCount;
  int errCount;

  in_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .clr        (clr),
    .clean_out  (clean_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .event_cnt  (event_cnt),
    .glitch_cnt (glitch_cnt)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive raw_in to a new level and check the full qualification window:
  // five falling-edge samples at the old level, then the accepted level with
  // its strobe, then the strobe gone. clrAtAccept asserts clr for the edge
  // that accepts the rise.
  task automatic applyStimulus(input logic level, input logic clrAtAccept,
                               input string tag);
    raw_in = level;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput({tag, "_hold"}, {31'd0, clean_out}, {31'd0, ~level});
    end
    if (clrAtAccept) clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput({tag, "_clean"}, {31'd0, clean_out}, {31'd0, level});
    checkOutput({tag, "_rise"},  {31'd0, rise_pulse}, {31'd0, level});
    checkOutput({tag, "_fall"},  {31'd0, fall_pulse}, {31'd0, ~level});
    @(negedge clk);
    checkOutput({tag, "_strobe_off"}, {30'd0, rise_pulse, fall_pulse}, 32'd0);
  endtask

  initial begin
    checkCount = 0;
    errCount   = 0;
    rst        = 1'b0;
    raw_in     = 1'b1;
    clr        = 1'b0;

    // 1. Reset with raw high, outputs all zero, then qualify the rise.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("rst_outputs", {14'd0, clean_out, rise_pulse, fall_pulse,
                                  event_cnt != 16'd0, glitch_cnt != 16'd0}, 32'd0);
    end
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, "rise1");
    checkOutput("rise1_event", {16'd0, event_cnt}, 32'd1);

    // 2. Two-cycle low glitch while high: no fall, one glitch.
    raw_in = 1'b0;
    stepCycles(2);
    raw_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("glitch_hi_state", {30'd0, clean_out, fall_pulse}, 32'd2);
    end
    checkOutput("glitch_hi_count", {16'd0, glitch_cnt}, 32'd1);

    // 3. Sustained low: fall accepted, event count unchanged.
    applyStimulus(1'b0, 1'b0, "fall1");
    checkOutput("fall1_event", {16'd0, event_cnt}, 32'd1);
    checkOutput("fall1_glitch", {16'd0, glitch_cnt}, 32'd1);

    // 4. Reset asserted mid rise-wait (cnt=2) takes effect immediately.
    raw_in = 1'b1;
    stepCycles(4);
    rst = 1'b0;
    #1;
    checkOutput("midrst_clean", {31'd0, clean_out}, 32'd0);
    checkOutput("midrst_counts", {event_cnt, glitch_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, "rise2");
    checkOutput("rise2_event", {16'd0, event_cnt}, 32'd1);

    // 5. clr coincident with an accepted rise: clr wins, FSM unaffected.
    applyStimulus(1'b0, 1'b0, "fall2");
    applyStimulus(1'b1, 1'b1, "rise3");
    checkOutput("clr_event", {16'd0, event_cnt}, 32'd0);
    checkOutput("clr_clean", {31'd0, clean_out}, 32'd1);

    // Toggling every cycle from low: never accepted, one glitch per high sample.
    applyStimulus(1'b0, 1'b0, "fall3");
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      raw_in = (i % 2 == 0);
      @(negedge clk);
      checkOutput("toggle_state", {29'd0, clean_out, rise_pulse, fall_pulse}, 32'd0);
    end
    raw_in = 1'b0;
    stepCycles(6);
    checkOutput("toggle_glitches", {16'd0, glitch_cnt}, 32'd10);
    checkOutput("toggle_events", {16'd0, event_cnt}, 32'd0);

    // 6. Event counter saturation from a preload of 0xFFFC.
    force dut.eventCnt_q = 16'hFFFC;
    #1;
    release dut.eventCnt_q;
    for (int r = 0; r < 5; r++) begin
      applyStimulus(1'b1, 1'b0, "sat_rise");
      checkOutput("sat_event", {16'd0, event_cnt},
                  (r < 3) ? 32'hFFFD + 32'(r) : 32'hFFFF);
      applyStimulus(1'b0, 1'b0, "sat_fall");
    end

    // Glitch counter saturation from 0xFFFF with one more glitch.
    force dut.glitchCnt_q = 16'hFFFF;
    #1;
    release dut.glitchCnt_q;
    raw_in = 1'b1;
    stepCycles(2);
    raw_in = 1'b0;
    stepCycles(8);
    checkOutput("sat_glitch", {16'd0, glitch_cnt}, 32'hFFFF);
    checkOutput("sat_glitch_clean", {31'd0, clean_out}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/in_conditioner.md
Name: in_conditioner

Overview:
Input conditioning stage directly upstream of the fp block. It takes an asynchronous single-bit raw signal (switch/sensor), synchronises it, debounces it with a 4-state FSM, and drives the clean level that fp consumes as in1. It also gives one-cycle rise/fall strobes and saturating 16-bit counters of qualified rising edges and rejected glitches, for status display.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a new level must hold before acceptance; legal range 2..255.
CNT_W, 8, width of the internal debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset (0 = reset asserted)
raw_in  input  1  unsynchronised raw input
clr  input  1  synchronous clear of event_cnt and glitch_cnt, active-high
clean_out  output  1  debounced level, feeds fp in1
rise_pulse  output  1  one-cycle strobe on accepted 0->1
fall_pulse  output  1  one-cycle strobe on accepted 1->0
event_cnt  output  16  accepted rising edges, saturating
glitch_cnt  output  16  rejected transitions (both polarities), saturating

Behaviour:
- Reset (rst=0, asynchronous): sync flops s1=s2=0, state=S_LOW, debounce cnt=0, clean_out=0, rise_pulse=0, fall_pulse=0, event_cnt=0, glitch_cnt=0. Reset takes effect immediately, mid-debounce included. Pending qualification is discarded. No strobe is emitted on reset entry or release.
- Synchroniser: s1<=raw_in, s2<=s1. The FSM sees only s2, called sync.
- FSM states: S_LOW, S_RISE_WAIT, S_HIGH, S_FALL_WAIT.
  - S_LOW: sync=1 -> S_RISE_WAIT, cnt<=1. Otherwise stay.
  - S_RISE_WAIT, sync=0: -> S_LOW, cnt<=0, glitch_cnt++.
  - S_RISE_WAIT, sync=1 and cnt+1==DEBOUNCE_CYCLES: -> S_HIGH, clean_out<=1, rise_pulse<=1, event_cnt++.
  - S_RISE_WAIT, otherwise: cnt<=cnt+1.
  - S_HIGH: sync=0 -> S_FALL_WAIT, cnt<=1. Otherwise stay.
  - S_FALL_WAIT, sync=1: -> S_HIGH, cnt<=0, glitch_cnt++.
  - S_FALL_WAIT, sync=0 and cnt+1==DEBOUNCE_CYCLES: -> S_LOW, clean_out<=0, fall_pulse<=1.
  - S_FALL_WAIT, otherwise: cnt<=cnt+1.
- Latency: let raw_in first be sampled at 1 on edge k and stay stable. clean_out rises at edge k+1+DEBOUNCE_CYCLES, and rise_pulse is high for exactly that one cycle. The fall path is symmetric.
- Strobes: rise_pulse and fall_pulse are registered, high for exactly one cycle, and never high together.
- clean_out is registered and glitch-free. It changes only on FSM acceptance.
- Counters: 16-bit. They saturate at 0xFFFF and never wrap.
- clr=1 clears both counters on the next edge. If clr and an increment land in the same cycle, clr wins and the counter reads 0.
- clr does not affect the FSM, clean_out or the strobes.
- A pulse on sync shorter than DEBOUNCE_CYCLES cycles leaves clean_out unchanged and counts exactly one glitch.
- raw_in toggling every cycle never reaches acceptance. The FSM alternates between a stable state and its WAIT state, with glitch_cnt incrementing once per return.

Test Plan:
1. rst=0 for 2 cycles with raw_in=1, then release -> all outputs 0 throughout reset, state S_LOW. Once raw_in has been held (DEBOUNCE_CYCLES=4), clean_out rises exactly 5 edges after raw_in is first sampled, rise_pulse is 1 for one cycle, event_cnt=1.
2. From clean_out=1, drop raw_in for 2 cycles then restore -> clean_out stays 1, fall_pulse never asserts, glitch_cnt=1.
3. Hold raw_in=0 for 4+ cycles from S_HIGH -> clean_out falls 5 edges after the first 0 sample, fall_pulse is one cycle, event_cnt unchanged.
4. Assert rst=0 mid-S_RISE_WAIT (cnt=2) -> immediately clean_out=0 and counters=0. After release with raw_in still 1, a full 5-edge qualification is required again.
5. Assert clr in the same cycle as an accepted rise -> event_cnt=0 the next cycle, clean_out=1, rise_pulse=1.
6. Force event_cnt to 0xFFFE via 2 extra accepted rises from preload (or a long run), then 3 more accepted rises -> event_cnt holds 0xFFFF with no wrap.
